cw_deserializer: RTL and testbench

//   Receive-side front end for the n48k32b7 burst-error-correcting decoder. Collects a bit-serial

---
 rtl/cw_deserializer.sv | 134 +++++++++++++
 tb/tb_cw_deserializer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cw_deserializer.sv
// Bit-serial to 48-bit codeword deserializer with sync alignment and a small output FIFO.
// Codewords leave on a valid/ready port; cw_out[0] is the first bit received.
module cw_deserializer #(
   parameter int N     = 48,
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         bit_valid,
   input  logic                         bit_in,
   input  logic                         sync,
   output logic [0:N-1]                 cw_out,
   output logic                         cw_valid,
   input  logic                         cw_ready,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         frame_err,
   output logic                         overflow,
   input  logic                         clr_ovf,
   output logic                         o_dbg_state
);

   localparam int CW = $clog2(N);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = $clog2(DEPTH + 1);

   typedef enum logic {S_IDLE = 1'b0, S_COLLECT = 1'b1} state_t;

   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_count, w_count_nxt;
   logic [0:N-1]    r_shift;
   logic            w_store, w_complete, w_ferr;
   logic [CW-1:0]   w_pos;
   logic [0:N-1]    w_word;

   logic [0:N-1]    r_mem [DEPTH];
   logic [PW-1:0]   r_rd_ptr, r_wr_ptr;
   logic [LW-1:0]   r_level;
   logic            r_frame_err, r_overflow;
   logic            w_pop, w_full, w_push, w_drop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_store     = 1'b0;
      w_pos       = '0;
      w_complete  = 1'b0;
      w_ferr      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bit_valid && sync) begin
               w_store     = 1'b1;
               w_count_nxt = CW'(1);
               w_state_nxt = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (bit_valid) begin
               w_store = 1'b1;
               // A sync mid-word restarts framing at bit 0 and drops the partial word.
               if (sync && (r_count != '0)) begin
                  w_ferr      = 1'b1;
                  w_count_nxt = CW'(1);
               end else begin
                  w_pos = r_count;
                  if (r_count == CW'(N - 1)) begin
                     w_complete  = 1'b1;
                     w_count_nxt = '0;
                  end else begin
                     w_count_nxt = r_count + CW'(1);
                  end
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_word = {r_shift[0:N-2], bit_in};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_count <= '0;
         r_shift <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         if (w_store) r_shift[w_pos] <= bit_in;
      end
   end

   assign w_pop  = (r_level != '0) && cw_ready;
   assign w_full = (r_level == LW'(DEPTH));
   // A pop in the completion cycle frees the slot the new word needs.
   assign w_push = w_complete && (!w_full || w_pop);
   assign w_drop = w_complete && !w_push;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_ptr    <= '0;
         r_wr_ptr    <= '0;
         r_level     <= '0;
         r_frame_err <= 1'b0;
         r_overflow  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
            r_wr_ptr        <= ptr_inc(r_wr_ptr);
         end
         if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
         r_frame_err <= w_ferr;
         if (w_drop)       r_overflow <= 1'b1;
         else if (clr_ovf) r_overflow <= 1'b0;
      end
   end

   assign cw_valid    = (r_level != '0);
   assign cw_out      = cw_valid ? r_mem[r_rd_ptr] : '0;
   assign level       = r_level;
   assign frame_err   = r_frame_err;
   assign overflow    = r_overflow;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cw_deserializer.sv
// Directed bench for cw_deserializer: framing, FIFO ordering, overflow, resync and reset.
module tb_cw_deserializer;

   logic         clk = 1'b0;
   logic         rst;
   logic         bit_valid, bit_in, sync;
   logic [0:47]  cw_out;
   logic         cw_valid, cw_ready;
   logic [1:0]   level;
   logic         frame_err, overflow, clr_ovf;
   logic         o_dbg_state;

   int           n_checks = 0;
   int           n_pass   = 0;
   logic         mon_en   = 1'b0;
   logic [47:0]  exp_q[$];

   cw_deserializer #(.N(48), .DEPTH(2)) dut (
      .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .sync(sync),
      .cw_out(cw_out), .cw_valid(cw_valid), .cw_ready(cw_ready), .level(level),
      .frame_err(frame_err), .overflow(overflow), .clr_ovf(clr_ovf),
      .o_dbg_state(o_dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input logic s);
      bit_valid = 1'b1;
      bit_in    = b;
      sync      = s;
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      sync      = 1'b0;
   endtask

   task automatic send_word(input logic [47:0] w, input logic with_sync);
      for (int i = 47; i >= 0; i--) send_bit(w[i], with_sync && (i == 47));
   endtask

   // Scoreboard for the streaming test: every accepted head must match the queue front.
   always @(negedge clk) begin
      if (mon_en && cw_valid && cw_ready) begin
         if (exp_q.size() == 0) check("t4_extra_word", 64'(cw_out), 64'hx);
         else check("t4_data", 64'(cw_out), 64'(exp_q.pop_front()));
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [47:0] w1, wa, wb, wc, wd, we, wf, wg, wh, wj, wk, wr, junk;
      w1 = 48'hDEADBEEF_C0DE;
      wa = 48'h1111_2222_3333; wb = 48'h4444_5555_6666; wc = 48'h7777_8888_9999;
      wd = 48'hA5A5_0F0F_C3C3; junk = 48'hFFFF_FFFF_FFFF;
      we = 48'h0123_4567_89AB; wf = 48'hCDEF_0123_4567; wg = 48'h8000_0000_0001;
      wh = 48'hFEDC_BA98_7654; wj = 48'hAAAA_AAAA_AAAA; wk = 48'h5555_0000_FFFF;

      rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; sync = 1'b0;
      cw_ready = 1'b0; clr_ovf = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 64'(cw_valid), 0);
      check("rst_cw_out", 64'(cw_out), 0);
      check("rst_level", 64'(level), 0);
      check("rst_frame_err", 64'(frame_err), 0);
      check("rst_overflow", 64'(overflow), 0);
      check("rst_state", 64'(o_dbg_state), 0);
      rst = 1'b0;
      idle();

      // Single codeword, consumer always ready: one-cycle valid one clock after bit 47.
      cw_ready = 1'b1;
      for (int i = 47; i >= 1; i--) send_bit(w1[i], i == 47);
      check("t1_valid_early", 64'(cw_valid), 0);
      send_bit(w1[0], 1'b0);
      check("t1_valid", 64'(cw_valid), 1);
      check("t1_data", 64'(cw_out), 64'(w1));
      idle();
      check("t1_valid_drop", 64'(cw_valid), 0);
      check("t1_level", 64'(level), 0);

      // Three back-to-back words, no drain: third is dropped.
      cw_ready = 1'b0;
      send_word(wa, 1'b1);
      send_word(wb, 1'b0);
      send_word(wc, 1'b0);
      check("t2_level", 64'(level), 2);
      check("t2_overflow", 64'(overflow), 1);
      check("t2_head1", 64'(cw_out), 64'(wa));
      cw_ready = 1'b1;
      idle();
      check("t2_head2", 64'(cw_out), 64'(wb));
      check("t2_level1", 64'(level), 1);
      idle();
      check("t2_empty", 64'(cw_valid), 0);
      cw_ready = 1'b0;
      check("t2_ovf_sticky", 64'(overflow), 1);
      clr_ovf = 1'b1;
      idle();
      clr_ovf = 1'b0;
      check("t2_ovf_clr", 64'(overflow), 0);

      // Resync at bit 20 of a word.
      for (int i = 0; i < 20; i++) send_bit(junk[i], i == 0);
      check("t3_no_ferr_yet", 64'(frame_err), 0);
      send_bit(wd[47], 1'b1);
      check("t3_ferr_pulse", 64'(frame_err), 1);
      send_bit(wd[46], 1'b0);
      check("t3_ferr_clear", 64'(frame_err), 0);
      for (int i = 45; i >= 0; i--) send_bit(wd[i], 1'b0);
      check("t3_level", 64'(level), 1);
      check("t3_data", 64'(cw_out), 64'(wd));
      cw_ready = 1'b1;
      idle();
      cw_ready = 1'b0;
      check("t3_level0", 64'(level), 0);

      // Full FIFO with a pop on the completion edge.
      send_word(we, 1'b1);
      send_word(wf, 1'b0);
      for (int i = 47; i >= 1; i--) send_bit(wg[i], 1'b0);
      check("t5_full", 64'(level), 2);
      cw_ready = 1'b1;
      send_bit(wg[0], 1'b0);
      cw_ready = 1'b0;
      check("t5_level", 64'(level), 2);
      check("t5_no_ovf", 64'(overflow), 0);
      check("t5_head", 64'(cw_out), 64'(wf));
      cw_ready = 1'b1;
      idle();
      check("t5_tail", 64'(cw_out), 64'(wg));
      check("t5_level1", 64'(level), 1);
      idle();
      cw_ready = 1'b0;
      check("t5_level0", 64'(level), 0);

      // Random gaps and random back-pressure over 100 codewords.
      mon_en = 1'b1;
      for (int k = 0; k < 100; k++) begin
         wr = {16'($urandom), 32'($urandom)};
         exp_q.push_back(wr);
         for (int i = 47; i >= 0; i--) begin
            while ($urandom_range(0, 1) == 1) begin
               cw_ready = 1'($urandom_range(0, 1));
               idle();
            end
            cw_ready = 1'($urandom_range(0, 1));
            send_bit(wr[i], (k == 0) && (i == 47));
         end
      end
      cw_ready = 1'b1;
      for (int c = 0; c < 200 && exp_q.size() != 0; c++) idle();
      idle();
      mon_en   = 1'b0;
      cw_ready = 1'b0;
      check("t4_drained", 64'(exp_q.size()), 0);
      check("t4_no_ovf", 64'(overflow), 0);
      check("t4_level0", 64'(level), 0);

      // Reset mid-word with one word queued.
      send_word(wh, 1'b1);
      for (int i = 47; i >= 18; i--) send_bit(wj[i], 1'b0);
      check("t6_queued", 64'(level), 1);
      rst = 1'b1;
      #1;
      check("t6_valid", 64'(cw_valid), 0);
      check("t6_cw_out", 64'(cw_out), 0);
      check("t6_level", 64'(level), 0);
      check("t6_frame_err", 64'(frame_err), 0);
      check("t6_overflow", 64'(overflow), 0);
      check("t6_state", 64'(o_dbg_state), 0);
      idle();
      rst = 1'b0;
      idle();
      send_word(wj, 1'b0);
      check("t6_ignored_valid", 64'(cw_valid), 0);
      check("t6_ignored_state", 64'(o_dbg_state), 0);
      send_word(wk, 1'b1);
      check("t6_resync_valid", 64'(cw_valid), 1);
      check("t6_resync_data", 64'(cw_out), 64'(wk));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
